// File: rtl/axi4_pkg.sv
// Shared types for the AXI4 write-to-SRAM slave: burst encodings, response
// codes and the write-path FSM state.
package axi4_pkg;

  typedef enum logic [1:0] {
    FIXED = 2'd0,
    INCR  = 2'd1,
    WRAP  = 2'd2
  } burst_e;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] EXOKAY = 2'b01;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/axi4_burst_addr_gen.sv
// Combinational AXI4 beat-address generator and burst-legality check.
// WRAP support is compiled only when AXI4_WR_SRAM_WRAP_EN is defined.
module axi4_burst_addr_gen
  import axi4_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int STRB_WIDTH = 8
) (
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [2:0]            size_i,
  input  logic [7:0]            len_i,
  input  logic [1:0]            burst_i,
  output logic [ADDR_WIDTH-1:0] next_addr_o,
  output logic                  legal_o
);

  localparam logic [3:0] MAX_SIZE = 4'($clog2(STRB_WIDTH));

  logic [ADDR_WIDTH-1:0] incr;
  logic [ADDR_WIDTH-1:0] size_mask;
  logic [ADDR_WIDTH-1:0] aligned;

  always_comb begin
    incr      = ADDR_WIDTH'(1) << size_i;
    size_mask = incr - ADDR_WIDTH'(1);
    aligned   = addr_i & ~size_mask;
  end

`ifdef AXI4_WR_SRAM_WRAP_EN
  logic [ADDR_WIDTH-1:0] wrap_mask;
  logic                  wrap_ok;

  // Wrap window is (len+1) beats of 1<<size bytes; only 2/4/8/16 beats allowed.
  always_comb begin
    wrap_mask = (ADDR_WIDTH'({1'b0, len_i} + 9'd1) << size_i) - ADDR_WIDTH'(1);
    wrap_ok   = (len_i == 8'd1 || len_i == 8'd3 || len_i == 8'd7 || len_i == 8'd15)
                && ((addr_i & size_mask) == '0);
  end
`endif

  always_comb begin
    next_addr_o = addr_i;
    legal_o     = ({1'b0, size_i} <= MAX_SIZE);
    case (burst_i)
      FIXED: next_addr_o = addr_i;
      INCR:  next_addr_o = aligned + incr;
`ifdef AXI4_WR_SRAM_WRAP_EN
      WRAP: begin
        next_addr_o = (aligned & ~wrap_mask) | ((aligned + incr) & wrap_mask);
        legal_o     = legal_o && wrap_ok;
      end
`endif
      default: legal_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/axi4_wr_sram_slave.sv
// AXI4 write-channel slave feeding a single-port SRAM write port, one burst
// at a time. Define AXI4_WR_SRAM_WRAP_EN to accept WRAP bursts.
module axi4_wr_sram_slave
  import axi4_pkg::*;
#(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int MEM_DEPTH  = 1024
) (
  input  logic                         aclk,
  input  logic                         areset,
  input  logic                         awvalid,
  input  logic [ID_WIDTH-1:0]          awid,
  input  logic [ADDR_WIDTH-1:0]        awaddr,
  input  logic [7:0]                   awlen,
  input  logic [2:0]                   awsize,
  input  logic [1:0]                   awburst,
  input  logic [3:0]                   awcache,
  input  logic [2:0]                   awprot,
  input  logic [3:0]                   awqos,
  input  logic [3:0]                   awregion,
  output logic                         awready,
  input  logic                         wvalid,
  input  logic [DATA_WIDTH-1:0]        wdata,
  input  logic [STRB_WIDTH-1:0]        wstrb,
  input  logic                         wlast,
  output logic                         wready,
  output logic                         bvalid,
  output logic [ID_WIDTH-1:0]          bid,
  output logic [1:0]                   bresp,
  input  logic                         bready,
  output logic                         mem_wen,
  output logic [$clog2(MEM_DEPTH)-1:0] mem_waddr,
  output logic [DATA_WIDTH-1:0]        mem_wdata,
  output logic [STRB_WIDTH-1:0]        mem_wstrb,
  output state_e                       dbg_state
);

  // Handshake rule on every channel: a transfer happens on a rising edge where
  // valid and ready are both high; ready comes from a flop and never looks at valid.

  localparam int          IDX_W     = $clog2(MEM_DEPTH);
  localparam int          OFF_W     = $clog2(STRB_WIDTH);
  localparam logic [63:0] MEM_BYTES = 64'(MEM_DEPTH) * 64'(STRB_WIDTH);

  state_e state_q, state_d;

  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            len_q, len_d;
  logic [2:0]            size_q, size_d;
  logic [1:0]            burst_q, burst_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  err_q, err_d;
  logic                  drop_q, drop_d;

  logic                  awready_q, awready_d;
  logic                  wready_q, wready_d;
  logic                  bvalid_q, bvalid_d;
  logic [ID_WIDTH-1:0]   bid_q, bid_d;
  logic [1:0]            bresp_q, bresp_d;
  logic                  mem_wen_q, mem_wen_d;
  logic [IDX_W-1:0]      mem_waddr_q, mem_waddr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [STRB_WIDTH-1:0] mem_wstrb_q, mem_wstrb_d;

  logic aw_hs, w_hs, b_hs, last_beat, in_range, beat_err;

  logic [ADDR_WIDTH-1:0] gen_addr, gen_next;
  logic [2:0]            gen_size;
  logic [7:0]            gen_len;
  logic [1:0]            gen_burst;
  logic                  gen_legal;

  logic unused_aw_attr;
  assign unused_aw_attr = ^{awcache, awprot, awqos, awregion};

  assign aw_hs     = awvalid && awready_q;
  assign w_hs      = wvalid && wready_q;
  assign b_hs      = bready && bvalid_q;
  assign last_beat = (cnt_q == len_q);
  assign in_range  = (64'(addr_q) < MEM_BYTES);

  // While idle the generator judges the incoming AW request; afterwards it
  // steps the latched burst.
  always_comb begin
    if (state_q == IDLE) begin
      gen_addr  = awaddr;
      gen_size  = awsize;
      gen_len   = awlen;
      gen_burst = awburst;
    end else begin
      gen_addr  = addr_q;
      gen_size  = size_q;
      gen_len   = len_q;
      gen_burst = burst_q;
    end
  end

  axi4_burst_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .STRB_WIDTH (STRB_WIDTH)
  ) u_addr_gen (
    .addr_i      (gen_addr),
    .size_i      (gen_size),
    .len_i       (gen_len),
    .burst_i     (gen_burst),
    .next_addr_o (gen_next),
    .legal_o     (gen_legal)
  );

  always_ff @(posedge aclk) begin
    if (areset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (aw_hs) state_d = DATA;
      DATA:    if (w_hs && last_beat) state_d = RESP;
      RESP:    if (b_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    awready_d = (state_d == IDLE);
    wready_d  = (state_d == DATA);
    bvalid_d  = (state_d == RESP);
  end

  always_comb begin
    id_d        = id_q;
    addr_d      = addr_q;
    len_d       = len_q;
    size_d      = size_q;
    burst_d     = burst_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    drop_d      = drop_q;
    bid_d       = bid_q;
    bresp_d     = bresp_q;
    mem_wen_d   = 1'b0;
    mem_waddr_d = mem_waddr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    beat_err    = 1'b0;

    if (aw_hs) begin
      id_d    = awid;
      addr_d  = awaddr;
      len_d   = awlen;
      size_d  = awsize;
      burst_d = awburst;
      cnt_d   = 8'd0;
      drop_d  = !gen_legal;
      err_d   = !gen_legal;
    end

    if (w_hs) begin
      beat_err = (wlast != last_beat) || (!drop_q && !in_range);
      if (!drop_q && in_range) begin
        mem_wen_d   = 1'b1;
        mem_waddr_d = IDX_W'(addr_q >> OFF_W);
        mem_wdata_d = wdata;
        mem_wstrb_d = wstrb;
      end
      err_d  = err_q || beat_err;
      addr_d = gen_next;
      cnt_d  = cnt_q + 8'd1;
      if (last_beat) begin
        bid_d   = id_q;
        bresp_d = (err_q || beat_err) ? SLVERR : OKAY;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      id_d_unused_guard: begin end
      id_q        <= '0;
      addr_q      <= '0;
      len_q       <= '0;
      size_q      <= '0;
      burst_q     <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      drop_q      <= 1'b0;
      awready_q   <= 1'b0;
      wready_q    <= 1'b0;
      bvalid_q    <= 1'b0;
      bid_q       <= '0;
      bresp_q     <= '0;
      mem_wen_q   <= 1'b0;
      mem_waddr_q <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
    end else begin
      id_q        <= id_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      size_q      <= size_d;
      burst_q     <= burst_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      drop_q      <= drop_d;
      awready_q   <= awready_d;
      wready_q    <= wready_d;
      bvalid_q    <= bvalid_d;
      bid_q       <= bid_d;
      bresp_q     <= bresp_d;
      mem_wen_q   <= mem_wen_d;
      mem_waddr_q <= mem_waddr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
    end
  end

  assign awready   = awready_q;
  assign wready    = wready_q;
  assign bvalid    = bvalid_q;
  assign bid       = bid_q;
  assign bresp     = bresp_q;
  assign mem_wen   = mem_wen_q;
  assign mem_waddr = mem_waddr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wstrb = mem_wstrb_q;
  assign dbg_state = state_q;

endmodule
